encoder_4x2_sched: RTL

//   Sequential 4-to-2 priority encoder: the inverse of the 2x4 decoder path.

---
 rtl/encoder_4x2_sched_if.sv | 26 ++
 rtl/encoder_4x2_sched.sv | 117 +++++++++++
 2 files changed

// File: rtl/encoder_4x2_sched_if.sv
// Request/index handshake bundle between the sequential priority encoder
// (slave) and the block that loads requests and consumes indices (master).
interface encoder_4x2_sched_if #(
    parameter int N     = 4,
    parameter int IDX_W = 2
);
    logic             en;
    logic             load;
    logic [N-1:0]     req_in;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             zero;
    logic             done;

    modport slave (
        input  en, load, req_in, out_ready,
        output out_idx, out_valid, busy, zero, done
    );

    modport master (
        output en, load, req_in, out_ready,
        input  out_idx, out_valid, busy, zero, done
    );
endinterface

// File: rtl/encoder_4x2_sched.sv
// Sequential 4-to-2 priority encoder: captures a request vector on load and
// presents the index of each set bit, highest first, over valid/ready.
module encoder_4x2_sched #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input logic                  clk,
    input logic                  rst,
    encoder_4x2_sched_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [N-1:0]     r_pend, w_pend_nxt;
    logic [IDX_W-1:0] r_out_idx, w_idx_nxt;
    logic             r_out_valid, w_valid_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_zero, w_zero_nxt;
    logic             r_done, w_done_nxt;
    logic             w_accept;
    logic [N-1:0]     w_rem;

    // Highest set bit of v; bit N-1 has top priority.
    function automatic logic [IDX_W-1:0] f_hi(input logic [N-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (v[k]) idx = IDX_W'(k);
        end
        return idx;
    endfunction

    // Handshake completion and the pending set left after the current index.
    always_comb begin
        w_accept = bus.en & r_out_valid & bus.out_ready;
        w_rem    = r_pend & ~(N'(1) << r_out_idx);
    end

    // Next state and next registered outputs; en=0 freezes state and
    // drops valid/pulses.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_idx_nxt   = r_out_idx;
        w_valid_nxt = 1'b0;
        w_zero_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        if (bus.en) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.load) begin
                        w_pend_nxt = bus.req_in;
                        if (bus.req_in != '0) begin
                            w_state_nxt = S_SERVE;
                            w_idx_nxt   = f_hi(bus.req_in);
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_zero_nxt  = 1'b1;
                        end
                    end
                end
                S_SERVE: begin
                    w_valid_nxt = 1'b1;
                    if (w_accept) begin
                        w_pend_nxt = w_rem;
                        if (w_rem != '0) begin
                            w_idx_nxt = f_hi(w_rem);
                        end else begin
                            w_state_nxt = S_DONE;
                            w_valid_nxt = 1'b0;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_pend_nxt  = '0;
                end
            endcase
        end
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pend      <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_zero      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_out_idx   <= w_idx_nxt;
            r_out_valid <= w_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_zero      <= w_zero_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign bus.out_idx   = r_out_idx;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.zero      = r_zero;
    assign bus.done      = r_done;
endmodule
